// File: rtl/sar_adc_seq_if.sv
// sar_adc_seq_if: scan control, comparator/DAC/S&H drive and
// result bus between the SAR sequencer and the analog top.
interface sar_adc_seq_if #(
  parameter int NCH = 18
);
  logic           en;
  logic [NCH-1:0] chan_mask;
  logic           comp_o;
  logic [NCH-1:0] cmp_sel;
  logic [9:0]     dac1;
  logic           dac1_en;
  logic           ad_rst;
  logic           ad_hold;
  logic [9:0]     res_data;
  logic [4:0]     res_chan;
  logic           res_vld;
  logic           busy;

  modport master (
    input  en, chan_mask, comp_o,
    output cmp_sel, dac1, dac1_en, ad_rst, ad_hold,
    output res_data, res_chan, res_vld, busy
  );

  modport slave (
    output en, chan_mask, comp_o,
    input  cmp_sel, dac1, dac1_en, ad_rst, ad_hold,
    input  res_data, res_chan, res_vld, busy
  );
endinterface

// File: rtl/sar_adc_seq.sv
// sar_adc_seq: round-robin SAR ADC scan sequencer.
// Define SAR_ADC_AVG_EN to average 4 conversions per channel.
module sar_adc_seq #(
  parameter int NCH        = 18,
  parameter int SETTLE_CYC = 4,
  parameter int SMP_CYC    = 8,
  parameter int BIT_CYC    = 2
) (
  input  logic           clk,
  input  logic           srst,
  sar_adc_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, SAMPLE, CONV, DONE
  } state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [3:0]     bitk;
  logic [9:0]     acc;
  logic [4:0]     ptr;

  logic [NCH-1:0] cmp_sel_q;
  logic [9:0]     dac1_q;
  logic           dac1_en_q;
  logic           ad_rst_q;
  logic           ad_hold_q;
  logic [9:0]     res_data_q;
  logic [4:0]     res_chan_q;
  logic           res_vld_q;
  logic           busy_q;

`ifdef SAR_ADC_AVG_EN
  logic [11:0]    sum;
  logic [1:0]     avg_cnt;
  logic [11:0]    sum_nx;
`endif

  logic           nxt_found;
  logic [4:0]     nxt_ptr;
  logic [9:0]     acc_nx;
  logic           at_sel;
  logic           go_idle;
  logic           win_end;

  // Lowest offset wins, so the current channel is the last candidate.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ptr   = ptr;
    for (int i = NCH; i >= 1; i--) begin
      if (bus.chan_mask[(int'(ptr) + i) % NCH]) begin
        nxt_found = 1'b1;
        nxt_ptr   = 5'((int'(ptr) + i) % NCH);
      end
    end
  end

  always_comb begin
    acc_nx  = bus.comp_o ? dac1_q : acc;
    at_sel  = (state == IDLE) || (state == DONE);
    go_idle = at_sel ? !(bus.en && nxt_found) : !bus.en;
    win_end = (cnt == 8'(BIT_CYC - 1));
`ifdef SAR_ADC_AVG_EN
    sum_nx  = sum + {2'b00, acc_nx};
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitk       <= '0;
      acc        <= '0;
      ptr        <= 5'(NCH - 1);
      cmp_sel_q  <= '0;
      dac1_q     <= '0;
      dac1_en_q  <= 1'b0;
      ad_rst_q   <= 1'b1;
      ad_hold_q  <= 1'b0;
      res_data_q <= '0;
      res_chan_q <= '0;
      res_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SAR_ADC_AVG_EN
      sum        <= '0;
      avg_cnt    <= '0;
`endif
    end else begin
      res_vld_q <= 1'b0;
      cnt       <= cnt + 8'd1;
      if (go_idle) begin
        state     <= IDLE;
        cmp_sel_q <= '0;
        dac1_q    <= '0;
        dac1_en_q <= 1'b0;
        ad_rst_q  <= 1'b1;
        ad_hold_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            state     <= SETTLE;
            ptr       <= nxt_ptr;
            cmp_sel_q <= NCH'(1) << nxt_ptr;
            dac1_q    <= '0;
            dac1_en_q <= 1'b1;
            ad_rst_q  <= 1'b1;
            ad_hold_q <= 1'b0;
            busy_q    <= 1'b1;
            cnt       <= '0;
`ifdef SAR_ADC_AVG_EN
            sum       <= '0;
            avg_cnt   <= '0;
`endif
          end
          SETTLE: begin
            if (cnt == 8'(SETTLE_CYC - 1)) begin
              state    <= SAMPLE;
              ad_rst_q <= 1'b0;
              cnt      <= '0;
            end
          end
          SAMPLE: begin
            if (cnt == 8'(SMP_CYC - 1)) begin
              state     <= CONV;
              ad_hold_q <= 1'b1;
              acc       <= '0;
              dac1_q    <= 10'h200;
              bitk      <= 4'd9;
              cnt       <= '0;
            end
          end
          CONV: begin
            if (win_end) begin
              cnt <= '0;
              acc <= acc_nx;
              if (bitk != 4'd0) begin
                bitk   <= bitk - 4'd1;
                dac1_q <= acc_nx | (10'd1 << (bitk - 4'd1));
              end else begin
`ifdef SAR_ADC_AVG_EN
                if (avg_cnt == 2'd3) begin
                  state      <= DONE;
                  ad_hold_q  <= 1'b0;
                  ad_rst_q   <= 1'b1;
                  res_data_q <= sum_nx[11:2];
                  res_chan_q <= ptr;
                  res_vld_q  <= 1'b1;
                end else begin
                  state     <= SAMPLE;
                  sum       <= sum_nx;
                  avg_cnt   <= avg_cnt + 2'd1;
                  ad_hold_q <= 1'b0;
                  ad_rst_q  <= 1'b0;
                end
`else
                state      <= DONE;
                ad_hold_q  <= 1'b0;
                ad_rst_q   <= 1'b1;
                res_data_q <= acc_nx;
                res_chan_q <= ptr;
                res_vld_q  <= 1'b1;
`endif
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmp_sel  = cmp_sel_q;
  assign bus.dac1     = dac1_q;
  assign bus.dac1_en  = dac1_en_q;
  assign bus.ad_rst   = ad_rst_q;
  assign bus.ad_hold  = ad_hold_q;
  assign bus.res_data = res_data_q;
  assign bus.res_chan = res_chan_q;
  assign bus.res_vld  = res_vld_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: directed checks of the SAR scan sequencer
// against a threshold comparator model.
module tb_sar_adc_seq;

  logic clk = 1'b0;
  logic srst;
  int   n_run = 0;
  int   n_fail = 0;

  int   mode;
  logic alt;
  int   conv_idx;
  logic ph;

  int   hold;
  int   ntr;
  int   tr [10];
  int   cmp_bad;
  logic [17:0] exp_sel;

  int   rt [8];
  int   rc [8];
  int   got;

  sar_adc_seq_if #(.NCH(18)) bus ();

  sar_adc_seq dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int thr;
  assign thr = (alt && conv_idx[0]) ? 702 : 700;
  assign bus.comp_o = (mode == 1) ? 1'b1 :
                      (mode == 2) ? 1'b0 :
                      (thr > int'(bus.dac1));

  always @(negedge clk) begin
    if (srst) begin
      conv_idx <= 0;
    end else if (ph && !bus.ad_hold) begin
      conv_idx <= conv_idx + 1;
    end
    ph <= bus.ad_hold;
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_sel"},     bus.cmp_sel, 0);
    chk({tag, "_dac1en"},  bus.dac1_en, 0);
    chk({tag, "_adrst"},   bus.ad_rst, 1);
    chk({tag, "_adhold"},  bus.ad_hold, 0);
    chk({tag, "_dac1"},    bus.dac1, 0);
    chk({tag, "_vld"},     bus.res_vld, 0);
  endtask

  // Called in the first SETTLE cycle; returns on the res_vld cycle.
  task automatic wait_vld(input int lim, output int n);
    n = 1;
    hold = 0;
    ntr = 0;
    cmp_bad = 0;
    while (!bus.res_vld && n < lim) begin
      if (bus.ad_hold) begin
        if (hold % 2 == 0 && ntr < 10) begin
          tr[ntr] = int'(bus.dac1);
          ntr++;
        end
        hold++;
      end
      if (bus.cmp_sel !== exp_sel) cmp_bad++;
      step();
      n++;
    end
    chk("vld_seen", bus.res_vld, 1);
  endtask

  task automatic collect(input int nres, input int lim,
                         input int chg_at, input logic [17:0] chg_mask);
    int c;
    c = 1;
    got = 0;
    while (got < nres && c < lim) begin
      if (c == chg_at) bus.chan_mask = chg_mask;
      if (bus.res_vld) begin
        rt[got] = c;
        rc[got] = int'(bus.res_chan);
        got++;
      end
      step();
      c++;
    end
    chk("collect_cnt", got, nres);
  endtask

  initial begin
    int n;
    int q;
    srst = 1'b1;
    bus.en = 1'b0;
    bus.chan_mask = '0;
    mode = 0;
    alt = 1'b0;
    step();
    step();
    chk_idle("rst");
    chk("rst_data", bus.res_data, 0);
    chk("rst_chan", bus.res_chan, 0);
    srst = 1'b0;

`ifdef SAR_ADC_AVG_EN
    alt = 1'b1;
    bus.chan_mask = 18'h00001;
    bus.en = 1'b1;
    exp_sel = 18'h00001;
    step();
    wait_vld(200, n);
    chk("avg_lat", n, 117);
    chk("avg_data", bus.res_data, 700);
    chk("avg_chan", bus.res_chan, 0);
    chk("avg_hold", hold, 80);
    chk("avg_sel", cmp_bad, 0);
    bus.en = 1'b0;
    q = 0;
    repeat (150) begin
      step();
      if (bus.res_vld) q++;
    end
    chk("avg_single", q, 0);
    chk_idle("avg_end");
`else
    // Single channel, threshold 700.
    bus.chan_mask = 18'h00001;
    bus.en = 1'b1;
    exp_sel = 18'h00001;
    step();
    chk("t1_sel0", bus.cmp_sel, 18'h00001);
    chk("t1_busy", bus.busy, 1);
    chk("t1_adrst", bus.ad_rst, 1);
    wait_vld(100, n);
    chk("t1_lat", n, 33);
    chk("t1_data", bus.res_data, 699);
    chk("t1_chan", bus.res_chan, 0);
    chk("t1_hold", hold, 20);
    chk("t1_sel", cmp_bad, 0);
    chk("t1_done_sel", bus.cmp_sel, 18'h00001);
    chk("t1_done_rst", bus.ad_rst, 1);
    bus.en = 1'b0;
    step();
    chk_idle("t1_end");
    chk("t1_hold_data", bus.res_data, 699);

    // Round-robin {0,5,17}, back-to-back.
    srst = 1'b1;
    step();
    srst = 1'b0;
    bus.chan_mask = 18'h20021;
    bus.en = 1'b1;
    step();
    collect(5, 400, 0, 18'h0);
    chk("t2_c0", rc[0], 0);
    chk("t2_c1", rc[1], 5);
    chk("t2_c2", rc[2], 17);
    chk("t2_c3", rc[3], 0);
    chk("t2_c4", rc[4], 5);
    chk("t2_t0", rt[0], 33);
    for (int i = 1; i < 5; i++)
      chk($sformatf("t2_gap%0d", i), rt[i] - rt[i-1], 33);
    bus.en = 1'b0;
    step();

    // Mask change mid-conversion takes effect at next selection.
    srst = 1'b1;
    step();
    srst = 1'b0;
    bus.chan_mask = 18'h20021;
    bus.en = 1'b1;
    step();
    collect(2, 200, 16, 18'h20001);
    chk("t2b_c0", rc[0], 0);
    chk("t2b_c1", rc[1], 17);
    bus.en = 1'b0;
    step();

    // Saturation both ways.
    srst = 1'b1;
    step();
    srst = 1'b0;
    bus.chan_mask = 18'h00001;
    exp_sel = 18'h00001;
    mode = 1;
    bus.en = 1'b1;
    step();
    wait_vld(100, n);
    chk("t3_hi_data", bus.res_data, 1023);
    chk("t3_hi_ntr", ntr, 10);
    for (int j = 0; j < 10; j++)
      chk($sformatf("t3_hi_tr%0d", j), tr[j], 1024 - (1 << (9 - j)));
    bus.en = 1'b0;
    step();
    mode = 2;
    bus.en = 1'b1;
    step();
    wait_vld(100, n);
    chk("t3_lo_data", bus.res_data, 0);
    for (int j = 0; j < 10; j++)
      chk($sformatf("t3_lo_tr%0d", j), tr[j], 1 << (9 - j));
    bus.en = 1'b0;
    step();
    mode = 0;

    // Abort at CONV cycle 10, then resume after aborted channel.
    srst = 1'b1;
    step();
    srst = 1'b0;
    bus.chan_mask = 18'h20021;
    bus.en = 1'b1;
    step();
    repeat (21) step();
    chk("t4_in_conv", bus.ad_hold, 1);
    bus.en = 1'b0;
    step();
    chk_idle("t4_abort");
    q = 0;
    repeat (40) begin
      step();
      if (bus.res_vld || bus.busy) q++;
    end
    chk("t4_quiet", q, 0);
    bus.en = 1'b1;
    exp_sel = 18'h00020;
    step();
    wait_vld(100, n);
    chk("t4_chan", bus.res_chan, 5);
    chk("t4_lat", n, 33);
    chk("t4_sel", cmp_bad, 0);
    bus.en = 1'b0;
    step();

    // Reset during SAMPLE.
    bus.en = 1'b1;
    step();
    repeat (5) step();
    chk("t5_sample_rst", bus.ad_rst, 0);
    chk("t5_sample_sel", bus.cmp_sel, 18'h20000);
    srst = 1'b1;
    step();
    chk_idle("t5_rst");
    chk("t5_rst_data", bus.res_data, 0);
    chk("t5_rst_chan", bus.res_chan, 0);
    srst = 1'b0;
    bus.chan_mask = 18'h00001;
    exp_sel = 18'h00001;
    step();
    wait_vld(100, n);
    chk("t5_chan", bus.res_chan, 0);
    chk("t5_data", bus.res_data, 699);
    chk("t5_lat", n, 33);
    bus.en = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
